ctrl_unit: RTL and testbench

- Main controller for the 8-bit single-cycle core.
- Decodes the 5-bit opcode that the datapath presents (instruction bits [18:14]) and drives every datapath control strobe in the same cycle.
- Tracks call-stack depth and a retired-instruction count, and enters a sticky FAULT state on stack overflow, stack underflow or an illegal opcode.
- Sits directly upstream of the datapath and consumes its opcode and its registered C/Z flags.

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/ctrl_unit_if.sv | 38 +++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/ctrl_unit.sv | 96 +++++++++
 tb/tb_ctrl_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, select encodings and state types for the core controller.
package ctrl_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b10000;
    localparam logic [4:0] OP_STORE = 5'b10001;
    localparam logic [4:0] OP_ILL0  = 5'b10010;
    localparam logic [4:0] OP_ILL1  = 5'b10011;
    localparam logic [4:0] OP_JMP   = 5'b10100;
    localparam logic [4:0] OP_JZ    = 5'b10101;
    localparam logic [4:0] OP_JNZ   = 5'b10110;
    localparam logic [4:0] OP_JC    = 5'b10111;
    localparam logic [4:0] OP_JNC   = 5'b11100;
    localparam logic [4:0] OP_CALL  = 5'b11101;
    localparam logic [4:0] OP_RET   = 5'b11110;
    localparam logic [4:0] OP_NOP   = 5'b11111;

    typedef enum logic [1:0] {PC_INC, PC_STACK, PC_ABS, PC_REL} pc_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_SH} wb_sel_t;
    typedef enum logic [1:0] {FC_NONE, FC_OVERFLOW, FC_UNDERFLOW, FC_ILLEGAL} fault_code_t;
    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic    sel_imm;
        logic    store;
        logic    en;
        logic    pop;
        logic    push;
        logic    sh_o_ALU;
        logic    R2_o_Rd;
        logic    regWrite;
        pc_sel_t pc_state;
        wb_sel_t what_the_faz;
    } strobes_t;

endpackage

// File: rtl/ctrl_unit_if.sv
// Controller <-> datapath bundle: opcode and flags in, control strobes and status out.
interface ctrl_unit_if #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RET_W       = 16
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [4:0]         command;
    logic               C_in;
    logic               Z_in;
    logic               sel_imm;
    logic               store;
    logic               en;
    logic               pop;
    logic               push;
    logic               sh_o_ALU;
    logic               R2_o_Rd;
    logic               regWrite;
    logic [1:0]         pc_state;
    logic [1:0]         what_the_faz;
    logic               fault;
    logic [1:0]         fault_code;
    logic [DEPTH_W-1:0] depth;
    logic [RET_W-1:0]   retired;

    modport master (
        input  command, C_in, Z_in,
        output sel_imm, store, en, pop, push, sh_o_ALU, R2_o_Rd, regWrite,
               pc_state, what_the_faz, fault, fault_code, depth, retired
    );

    modport slave (
        output command, C_in, Z_in,
        input  sel_imm, store, en, pop, push, sh_o_ALU, R2_o_Rd, regWrite,
               pc_state, what_the_faz, fault, fault_code, depth, retired
    );

endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decode; flags calls, returns and the illegal slots.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] command,
    input  logic       c_flag,
    input  logic       z_flag,
    output strobes_t   strobes,
    output logic       illegal,
    output logic       is_call,
    output logic       is_ret
);

    always_comb begin
        strobes = '0;
        illegal = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        casez (command)
            5'b00???: begin
                strobes.regWrite = 1'b1;
                strobes.en       = 1'b1;
            end
            5'b01???: begin
                strobes.regWrite = 1'b1;
                strobes.en       = 1'b1;
                strobes.sel_imm  = 1'b1;
            end
            5'b110??: begin
                strobes.regWrite     = 1'b1;
                strobes.en           = 1'b1;
                strobes.sh_o_ALU     = 1'b1;
                strobes.what_the_faz = WB_SH;
            end
            OP_LOAD: begin
                strobes.regWrite     = 1'b1;
                strobes.what_the_faz = WB_MEM;
            end
            OP_STORE: begin
                strobes.store   = 1'b1;
                strobes.R2_o_Rd = 1'b1;
            end
            OP_JMP: strobes.pc_state = PC_ABS;
            OP_JZ:  strobes.pc_state = z_flag  ? PC_REL : PC_INC;
            OP_JNZ: strobes.pc_state = !z_flag ? PC_REL : PC_INC;
            OP_JC:  strobes.pc_state = c_flag  ? PC_REL : PC_INC;
            OP_JNC: strobes.pc_state = !c_flag ? PC_REL : PC_INC;
            OP_CALL: begin
                strobes.push     = 1'b1;
                strobes.pc_state = PC_ABS;
                is_call          = 1'b1;
            end
            OP_RET: begin
                strobes.pop      = 1'b1;
                strobes.pc_state = PC_STACK;
                is_ret           = 1'b1;
            end
            OP_NOP: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Core controller: decode plus RUN/FAULT FSM, call-depth tracking and retired count.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RET_W       = 16
) (
    input logic         clk,
    input logic         rst,
    ctrl_unit_if.master bus
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    strobes_t           dec, strobes_out;
    logic               illegal, is_call, is_ret;
    logic               fault_hit, exec;
    state_t             state_q, state_d;
    fault_code_t        code_q, code_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [RET_W-1:0]   retired_q, retired_d;

    ctrl_decode u_decode (
        .command (bus.command),
        .c_flag  (bus.C_in),
        .z_flag  (bus.Z_in),
        .strobes (dec),
        .illegal (illegal),
        .is_call (is_call),
        .is_ret  (is_ret)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            code_q    <= FC_NONE;
            depth_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            depth_q   <= depth_d;
            retired_q <= retired_d;
        end
    end

    // The faulting instruction itself is squashed in the cycle it is detected.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        depth_d   = depth_q;
        retired_d = retired_q;
        fault_hit = 1'b0;
        exec      = 1'b0;
        if (state_q == RUN) begin
            if (illegal) begin
                fault_hit = 1'b1;
                code_d    = FC_ILLEGAL;
            end else if (is_call && depth_q == DEPTH_W'(STACK_DEPTH)) begin
                fault_hit = 1'b1;
                code_d    = FC_OVERFLOW;
            end else if (is_ret && depth_q == '0) begin
                fault_hit = 1'b1;
                code_d    = FC_UNDERFLOW;
            end
            if (fault_hit) begin
                state_d = FAULT;
            end else begin
                exec = 1'b1;
                if (is_call)
                    depth_d = depth_q + DEPTH_W'(1);
                else if (is_ret)
                    depth_d = depth_q - DEPTH_W'(1);
                if (retired_q != '1)
                    retired_d = retired_q + RET_W'(1);
            end
        end
        strobes_out = exec ? dec : '0;
    end

    assign bus.sel_imm      = strobes_out.sel_imm;
    assign bus.store        = strobes_out.store;
    assign bus.en           = strobes_out.en;
    assign bus.pop          = strobes_out.pop;
    assign bus.push         = strobes_out.push;
    assign bus.sh_o_ALU     = strobes_out.sh_o_ALU;
    assign bus.R2_o_Rd      = strobes_out.R2_o_Rd;
    assign bus.regWrite     = strobes_out.regWrite;
    assign bus.pc_state     = strobes_out.pc_state;
    assign bus.what_the_faz = strobes_out.what_the_faz;
    assign bus.fault        = (state_q == FAULT);
    assign bus.fault_code   = code_q;
    assign bus.depth        = depth_q;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: expected strobe vectors are queued at drive time.
module tb_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got, exp;

    ctrl_unit_if #(.STACK_DEPTH(8), .RET_W(16)) bus ();

    ctrl_unit #(.STACK_DEPTH(8), .RET_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Vector order: sel_imm store en pop push sh_o_ALU R2_o_Rd regWrite pc_state[1:0] wb[1:0]
    function automatic logic [11:0] model(input logic [4:0] op, input logic c, input logic z);
        logic si, st, e, po, pu, sh, r2, rw;
        logic [1:0] pc, wb;
        {si, st, e, po, pu, sh, r2, rw} = 8'h00;
        pc = 2'd0;
        wb = 2'd0;
        if (op[4] == 1'b0) begin
            rw = 1'b1; e = 1'b1; si = op[3];
        end else if (op[4:2] == 3'b110) begin
            rw = 1'b1; e = 1'b1; sh = 1'b1; wb = 2'd2;
        end else begin
            case (op)
                5'd16: begin rw = 1'b1; wb = 2'd1; end
                5'd17: begin st = 1'b1; r2 = 1'b1; end
                5'd20: pc = 2'd2;
                5'd21: pc = z ? 2'd3 : 2'd0;
                5'd22: pc = z ? 2'd0 : 2'd3;
                5'd23: pc = c ? 2'd3 : 2'd0;
                5'd28: pc = c ? 2'd0 : 2'd3;
                5'd29: begin pu = 1'b1; pc = 2'd2; end
                5'd30: begin po = 1'b1; pc = 2'd1; end
                default: ;
            endcase
        end
        return {si, st, e, po, pu, sh, r2, rw, pc, wb};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.sel_imm, bus.store, bus.en, bus.pop, bus.push, bus.sh_o_ALU,
                bus.R2_o_Rd, bus.regWrite, bus.pc_state, bus.what_the_faz};
    endfunction

    // Drive at posedge+1; push what the strobes must show this cycle.
    task automatic drive(input logic [4:0] op, input logic c, input logic z, input bit squashed);
        bus.command = op;
        bus.C_in    = c;
        bus.Z_in    = z;
        exp_q.push_back(squashed ? 12'h000 : model(op, c, z));
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.command = 5'b11111;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
        n_cmp++; if (bus.fault_code !== 2'd0) begin n_bad++; $display("FAIL reset_code got=%0d exp=0", bus.fault_code); end
        n_cmp++; if (bus.depth !== 4'd0) begin n_bad++; $display("FAIL reset_depth got=%0d exp=0", bus.depth); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_bad++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
    endtask

    task automatic test_alu();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'b00000, 1'b0, 1'b0, 1'b0);
            got = obs(); exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL alu_strobes[%0d] got=%h exp=%h", i, got, exp); end
            tick();
        end
        n_cmp++; if (bus.retired !== 16'd3) begin n_bad++; $display("FAIL alu_retired got=%0d exp=3", bus.retired); end
    endtask

    task automatic test_decode_mix();
        logic [4:0] ops[8] = '{5'b01010, 5'b00111, 5'b11001, 5'b11011, 5'b10000, 5'b10001, 5'b10100, 5'b11111};
        do_reset();
        foreach (ops[i]) begin
            drive(ops[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            got = obs(); exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL decode_op%b got=%h exp=%h", ops[i], got, exp); end
            tick();
        end
        n_cmp++; if (bus.retired !== 16'd8) begin n_bad++; $display("FAIL decode_retired got=%0d exp=8", bus.retired); end
    endtask

    task automatic test_branch();
        logic [4:0] ops[6] = '{5'b10101, 5'b10101, 5'b11100, 5'b11100, 5'b10110, 5'b10111};
        logic       cs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       zs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        foreach (ops[i]) begin
            drive(ops[i], cs[i], zs[i], 1'b0);
            got = obs(); exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, exp); end
            tick();
        end
        n_cmp++; if (bus.retired !== 16'd6) begin n_bad++; $display("FAIL branch_retired got=%0d exp=6", bus.retired); end
    endtask

    task automatic test_call_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(5'b11101, 1'b0, 1'b0, 1'b0);
            got = obs(); exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL call[%0d] got=%h exp=%h", i, got, exp); end
            tick();
        end
        n_cmp++; if (bus.depth !== 4'd8) begin n_bad++; $display("FAIL call_depth got=%0d exp=8", bus.depth); end
        drive(5'b11101, 1'b0, 1'b0, 1'b1);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL call9_squash got=%h exp=%h", got, exp); end
        tick();
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL ovf_fault got=%b exp=1", bus.fault); end
        n_cmp++; if (bus.fault_code !== 2'd1) begin n_bad++; $display("FAIL ovf_code got=%0d exp=1", bus.fault_code); end
        n_cmp++; if (bus.depth !== 4'd8) begin n_bad++; $display("FAIL ovf_depth got=%0d exp=8", bus.depth); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(i), 1'b0, 1'b0, 1'b1);
            got = obs(); exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL fault_hold[%0d] got=%h exp=%h", i, got, exp); end
            tick();
        end
        n_cmp++; if (bus.retired !== 16'd8) begin n_bad++; $display("FAIL ovf_retired got=%0d exp=8", bus.retired); end
        n_cmp++; if (bus.fault_code !== 2'd1) begin n_bad++; $display("FAIL ovf_code_sticky got=%0d exp=1", bus.fault_code); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(5'b11110, 1'b0, 1'b0, 1'b1);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ret_squash got=%h exp=%h", got, exp); end
        tick();
        n_cmp++; if (bus.fault_code !== 2'd2) begin n_bad++; $display("FAIL udf_code got=%0d exp=2", bus.fault_code); end
        n_cmp++; if (bus.depth !== 4'd0) begin n_bad++; $display("FAIL udf_depth got=%0d exp=0", bus.depth); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_bad++; $display("FAIL udf_retired got=%0d exp=0", bus.retired); end
    endtask

    task automatic test_illegal_async_reset();
        do_reset();
        drive(5'b11101, 1'b0, 1'b0, 1'b0);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ill_call got=%h exp=%h", got, exp); end
        tick();
        drive(5'b10011, 1'b0, 1'b0, 1'b1);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ill_squash got=%h exp=%h", got, exp); end
        tick();
        n_cmp++; if (bus.fault_code !== 2'd3) begin n_bad++; $display("FAIL ill_code got=%0d exp=3", bus.fault_code); end
        n_cmp++; if (bus.depth !== 4'd1) begin n_bad++; $display("FAIL ill_depth got=%0d exp=1", bus.depth); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL async_fault got=%b exp=0", bus.fault); end
        n_cmp++; if (bus.depth !== 4'd0) begin n_bad++; $display("FAIL async_depth got=%0d exp=0", bus.depth); end
        n_cmp++; if (bus.fault_code !== 2'd0) begin n_bad++; $display("FAIL async_code got=%0d exp=0", bus.fault_code); end
        drive(5'b00000, 1'b0, 1'b0, 1'b0);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_decode got=%h exp=%h", got, exp); end
        tick();
        rst = 1'b0;
        drive(5'b00000, 1'b0, 1'b0, 1'b0);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL post_rst_alu got=%h exp=%h", got, exp); end
        tick();
        n_cmp++; if (bus.retired !== 16'd1) begin n_bad++; $display("FAIL post_rst_retired got=%0d exp=1", bus.retired); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.command = 5'b11111;
        repeat (16'hFFFE) tick();
        n_cmp++; if (bus.retired !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre got=%h exp=fffe", bus.retired); end
        repeat (3) tick();
        n_cmp++; if (bus.retired !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got=%h exp=ffff", bus.retired); end
        drive(5'b01000, 1'b0, 1'b0, 1'b0);
        got = obs(); exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sat_decode got=%h exp=%h", got, exp); end
        tick();
        n_cmp++; if (bus.retired !== 16'hFFFF) begin n_bad++; $display("FAIL sat_final got=%h exp=ffff", bus.retired); end
    endtask

    initial begin
        bus.command = 5'b11111;
        bus.C_in    = 1'b0;
        bus.Z_in    = 1'b0;
        test_reset();
        test_alu();
        test_decode_mix();
        test_branch();
        test_call_overflow();
        test_underflow();
        test_illegal_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
